// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: decoded/renamed instructions, physical register
// tags, branch resolution results and the issue-queue entry.
package ooo_pkg;

    localparam int P_REG_W = 6;
    localparam int A_REG_W = 5;

    typedef struct packed {
        logic               valid;
        logic [A_REG_W-1:0] idx;
    } a_reg_t;

    typedef struct packed {
        logic   valid;
        a_reg_t rd;
        a_reg_t rs1;
        a_reg_t rs2;
        logic   is_branch;
    } dinstr_t;

    typedef struct packed {
        logic               valid;
        logic [P_REG_W-1:0] idx;
        logic               ready;
    } p_reg_t;

    typedef struct packed {
        logic               valid;
        logic [P_REG_W-1:0] idx;
    } p_dst_t;

    typedef struct packed {
        logic   valid;
        p_dst_t rd;
        p_reg_t rs1;
        p_reg_t rs2;
        logic   is_branch;
    } rinstr_t;

    typedef struct packed {
        logic valid;
        logic hit;
    } br_result_t;

    typedef struct packed {
        rinstr_t instr;
        logic    spec;
    } iq_entry_t;

    // A source is usable if unused, already ready, or being broadcast right now.
    function automatic logic src_ready(p_reg_t rs, p_reg_t wk);
        return !rs.valid || rs.ready || (wk.valid && (wk.idx == rs.idx));
    endfunction

endpackage

// File: rtl/iq_select.sv
// Find-first-set over the per-entry ready vector; lowest index (oldest) wins.
// Purely combinational.
module iq_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]         req,
    output logic                     found,
    output logic [$clog2(DEPTH)-1:0] idx
);

    localparam int IW = $clog2(DEPTH);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = IW'(i);
            end
        end
    end

endmodule

// File: rtl/issue_queue.sv
// Compacting out-of-order issue queue: in-order allocate, oldest-ready issue, squash of
// speculative entries on mispredict. Issue is combinational from registered state.
module issue_queue
    import ooo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_ni,
    input  rinstr_t    rinstr_i,
    input  p_reg_t     wakeup_i,
    input  br_result_t br_result_i,
    output logic       iq_full_o,
    output rinstr_t    issue_o,
    input  logic       issue_ready_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    iq_entry_t        ent     [DEPTH];
    iq_entry_t        ent_nxt [DEPTH];
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic             br_pending;
    logic             br_pending_nxt;

    logic             mispredict;
    logic             hit;
    logic             acc;
    logic             fire;
    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic [DEPTH-1:0] rdy_vec;
    logic [DEPTH-1:0] keep;
    iq_entry_t        new_ent;

    logic             unused_wk_ready;
    assign unused_wk_ready = wakeup_i.ready;

    assign mispredict = br_result_i.valid & ~br_result_i.hit;
    assign hit        = br_result_i.valid &  br_result_i.hit;
    assign iq_full_o  = (count == CW'(DEPTH));
    assign acc        = rinstr_i.valid & ~iq_full_o & ~mispredict;

    always_comb begin
        rdy_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy_vec[i] = ent[i].instr.valid & ent[i].instr.rs1.ready & ent[i].instr.rs2.ready;
        end
    end

    iq_select #(.DEPTH(DEPTH)) u_select (
        .req   (rdy_vec),
        .found (sel_found),
        .idx   (sel_idx)
    );

    always_comb begin
        issue_o = '0;
        if (sel_found && !mispredict) begin
            issue_o           = ent[sel_idx].instr;
            issue_o.valid     = 1'b1;
            issue_o.rs1.ready = 1'b1;
            issue_o.rs2.ready = 1'b1;
        end
    end

    assign fire = issue_o.valid & issue_ready_i;

    // A branch resolving this cycle makes the incoming instruction non-speculative.
    always_comb begin
        new_ent.instr           = rinstr_i;
        new_ent.instr.rs1.ready = src_ready(rinstr_i.rs1, wakeup_i);
        new_ent.instr.rs2.ready = src_ready(rinstr_i.rs2, wakeup_i);
        new_ent.spec            = br_pending & ~br_result_i.valid;
    end

    always_comb begin
        keep = '0;
        for (int i = 0; i < DEPTH; i++) begin
            keep[i] = ent[i].instr.valid
                    & ~(mispredict & ent[i].spec)
                    & ~(fire && (sel_idx == IW'(i)));
        end
    end

    // Removal by fire and squash by mispredict share one order-preserving compaction.
    always_comb begin
        iq_entry_t     cur;
        logic [CW-1:0] wr;
        for (int i = 0; i < DEPTH; i++) begin
            ent_nxt[i] = '0;
        end
        wr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cur               = ent[i];
            cur.instr.rs1.ready = src_ready(ent[i].instr.rs1, wakeup_i);
            cur.instr.rs2.ready = src_ready(ent[i].instr.rs2, wakeup_i);
            if (hit) begin
                cur.spec = 1'b0;
            end
            if (keep[i]) begin
                ent_nxt[wr[IW-1:0]] = cur;
                wr                  = wr + 1'b1;
            end
        end
        if (acc) begin
            ent_nxt[wr[IW-1:0]] = new_ent;
        end
        count_nxt = wr + {{(CW-1){1'b0}}, acc};
    end

    always_comb begin
        br_pending_nxt = br_pending;
        if (acc && rinstr_i.is_branch) begin
            br_pending_nxt = 1'b1;
        end else if (br_result_i.valid) begin
            br_pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            count      <= '0;
            br_pending <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
        end else begin
            count      <= count_nxt;
            br_pending <= br_pending_nxt;
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= ent_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Directed scenarios followed by random traffic, all checked every cycle against a
// queue-based reference model of the issue queue.
module tb_issue_queue;
    import ooo_pkg::*;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst_ni;
    rinstr_t    rinstr;
    p_reg_t     wakeup;
    br_result_t br_res;
    logic       issue_ready;
    logic       iq_full;
    rinstr_t    issue;

    int n_cmp  = 0;
    int n_fail = 0;

    iq_entry_t mq[$];
    logic      m_pend;

    always #5 clk = ~clk;

    issue_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_ni        (rst_ni),
        .rinstr_i      (rinstr),
        .wakeup_i      (wakeup),
        .br_result_i   (br_res),
        .iq_full_o     (iq_full),
        .issue_o       (issue),
        .issue_ready_i (issue_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic rinstr_t mk(int rd, bit s1v, int s1, bit s1r, bit s2v, int s2, bit s2r, bit br);
        rinstr_t r;
        r           = '0;
        r.valid     = 1'b1;
        r.rd.valid  = 1'b1;
        r.rd.idx    = 6'(rd);
        r.rs1.valid = s1v;
        r.rs1.idx   = 6'(s1);
        r.rs1.ready = s1r;
        r.rs2.valid = s2v;
        r.rs2.idx   = 6'(s2);
        r.rs2.ready = s2r;
        r.is_branch = br;
        return r;
    endfunction

    task automatic idle();
        rst_ni = 1'b1;
        rinstr = '0;
        wakeup = '0;
        br_res = '0;
    endtask

    task automatic wake(input int tag);
        wakeup       = '0;
        wakeup.valid = 1'b1;
        wakeup.idx   = 6'(tag);
    endtask

    function automatic bit src_ok(p_reg_t p);
        return !p.valid || p.ready;
    endfunction

    // Oldest entry whose sources are both available, unless a mispredict blocks issue.
    task automatic model_expect(output rinstr_t e, output int sel);
        e   = '0;
        sel = -1;
        if (!(br_res.valid && !br_res.hit)) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (src_ok(mq[i].instr.rs1) && src_ok(mq[i].instr.rs2)) begin
                    e           = mq[i].instr;
                    e.rs1.ready = 1'b1;
                    e.rs2.ready = 1'b1;
                    sel         = i;
                    break;
                end
            end
        end
    endtask

    task automatic model_step(input int sel);
        bit        mis;
        bit        fire;
        bit        accept;
        iq_entry_t ne;
        iq_entry_t t;
        iq_entry_t survivors[$];
        if (!rst_ni) begin
            mq.delete();
            m_pend = 1'b0;
            return;
        end
        mis    = br_res.valid && !br_res.hit;
        fire   = (sel >= 0) && issue_ready;
        accept = rinstr.valid && (mq.size() < DEPTH) && !mis;

        ne       = '0;
        ne.instr = rinstr;
        if (!rinstr.rs1.valid || (wakeup.valid && wakeup.idx == rinstr.rs1.idx)) ne.instr.rs1.ready = 1'b1;
        if (!rinstr.rs2.valid || (wakeup.valid && wakeup.idx == rinstr.rs2.idx)) ne.instr.rs2.ready = 1'b1;
        ne.spec = m_pend && !br_res.valid;

        for (int i = 0; i < mq.size(); i++) begin
            t = mq[i];
            if (wakeup.valid && t.instr.rs1.valid && t.instr.rs1.idx == wakeup.idx) t.instr.rs1.ready = 1'b1;
            if (wakeup.valid && t.instr.rs2.valid && t.instr.rs2.idx == wakeup.idx) t.instr.rs2.ready = 1'b1;
            if (br_res.valid && br_res.hit) t.spec = 1'b0;
            mq[i] = t;
        end
        if (fire) mq.delete(sel);
        if (mis) begin
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].spec) survivors.push_back(mq[i]);
            end
            mq = survivors;
        end
        if (accept) mq.push_back(ne);
        if (accept && rinstr.is_branch) m_pend = 1'b1;
        else if (br_res.valid)          m_pend = 1'b0;
    endtask

    // Inputs are driven at the falling edge; outputs compared just after, model advanced
    // with the same inputs the DUT sees at the next rising edge.
    task automatic cycle();
        rinstr_t e;
        int      sel;
        #1;
        model_expect(e, sel);
        chk("issue_o", {7'd0, issue}, {7'd0, e});
        chk("iq_full_o", {31'd0, iq_full}, {31'd0, (mq.size() == DEPTH)});
        model_step(sel);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic xchk(input string tag, input bit v, input int rd);
        #1;
        chk({tag, ".valid"}, {31'd0, issue.valid}, {31'd0, v});
        if (v) chk({tag, ".rd"}, {26'd0, issue.rd.idx}, 32'(rd));
    endtask

    task automatic xfull(input string tag, input bit v);
        #1;
        chk(tag, {31'd0, iq_full}, {31'd0, v});
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        cycle();
        rst_ni = 1'b1;
    endtask

    int wk_tags[7] = '{10, 11, 12, 14, 15, 16, 17};
    int wk_rds [7] = '{50, 51, 52, 54, 55, 56, 57};

    initial begin
        idle();
        rst_ni      = 1'b0;
        issue_ready = 1'b0;
        m_pend      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        xchk("reset_issue", 1'b0, 0);
        chk("reset_issue_all", {7'd0, issue}, 32'd0);
        xfull("reset_full", 1'b0);

        // Ready instruction issues the cycle after acceptance.
        issue_ready = 1'b1;
        rinstr = mk(40, 1, 5, 1, 0, 0, 0, 0);
        xchk("no_bypass", 1'b0, 0);
        cycle();
        idle();
        xchk("alloc_to_issue", 1'b1, 40);
        cycle();
        cycle();

        // Wakeup-to-issue latency.
        rinstr = mk(41, 1, 33, 0, 0, 0, 0, 0);
        cycle();
        idle();
        xchk("wait_a", 1'b0, 0);
        cycle();
        xchk("wait_b", 1'b0, 0);
        cycle();
        wake(33);
        xchk("wake_cycle", 1'b0, 0);
        cycle();
        idle();
        xchk("after_wake", 1'b1, 41);
        cycle();
        cycle();

        // Fill, drop when full, out-of-order issue from the middle, order preserved.
        for (int i = 0; i < DEPTH; i++) begin
            rinstr = mk(50 + i, 1, 10 + i, 0, 0, 0, 0, 0);
            cycle();
        end
        idle();
        xfull("full_after_fill", 1'b1);
        rinstr = mk(63, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        idle();
        wake(13);
        cycle();
        idle();
        xchk("mid_issue", 1'b1, 53);
        xfull("full_during_fire", 1'b1);
        cycle();
        xfull("full_after_fire", 1'b0);
        issue_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            wake(wk_tags[i]);
            cycle();
        end
        idle();
        issue_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            xchk("drain_order", 1'b1, wk_rds[i]);
            cycle();
        end
        xchk("drained", 1'b0, 0);
        cycle();

        // Mispredict squashes the three speculative entries.
        do_reset();
        issue_ready = 1'b1;
        rinstr = mk(20, 1, 2, 0, 0, 0, 0, 0); cycle();
        rinstr = mk(21, 1, 3, 0, 0, 0, 0, 1); cycle();
        for (int i = 0; i < 3; i++) begin
            rinstr = mk(22 + i, 1, 4, 0, 0, 0, 0, 0);
            cycle();
        end
        idle();
        wake(2);
        cycle();
        idle();
        br_res = '{valid: 1'b1, hit: 1'b0};
        rinstr = mk(25, 0, 0, 0, 0, 0, 0, 0);
        xchk("mispredict_no_issue", 1'b0, 0);
        cycle();
        idle();
        xchk("survivor_a", 1'b1, 20);
        cycle();
        wake(3);
        cycle();
        idle();
        xchk("survivor_b", 1'b1, 21);
        cycle();
        wake(4);
        cycle();
        idle();
        xchk("squashed_gone", 1'b0, 0);
        cycle();

        // Hit keeps everything; a later mispredict without a branch squashes nothing.
        do_reset();
        rinstr = mk(30, 1, 3, 0, 0, 0, 0, 1); cycle();
        for (int i = 0; i < 3; i++) begin
            rinstr = mk(31 + i, 1, 4, 0, 0, 0, 0, 0);
            cycle();
        end
        idle();
        br_res = '{valid: 1'b1, hit: 1'b1};
        cycle();
        idle();
        cycle();
        br_res = '{valid: 1'b1, hit: 1'b0};
        cycle();
        idle();
        wake(3);
        cycle();
        idle();
        xchk("hit_keep_br", 1'b1, 30);
        wake(4);
        cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            xchk("hit_keep_spec", 1'b1, 31 + i);
            cycle();
        end

        // Stable offer under back-pressure, then in-order follow-up.
        do_reset();
        issue_ready = 1'b0;
        rinstr = mk(1, 1, 7, 1, 0, 0, 0, 0); cycle();
        rinstr = mk(2, 1, 6, 0, 0, 0, 0, 0); cycle();
        rinstr = mk(3, 0, 0, 0, 1, 9, 1, 0); cycle();
        idle();
        for (int i = 0; i < 3; i++) begin
            xchk("hold_stable", 1'b1, 1);
            cycle();
        end
        issue_ready = 1'b1;
        xchk("hold_fire", 1'b1, 1);
        cycle();
        xchk("next_ready", 1'b1, 3);
        cycle();
        wake(6);
        cycle();
        idle();
        xchk("last", 1'b1, 2);
        cycle();

        // Reset wins over simultaneous accept, fire and mispredict.
        rinstr = mk(9, 0, 0, 0, 0, 0, 0, 0); cycle();
        rinstr = mk(10, 0, 0, 0, 0, 0, 0, 1); cycle();
        rinstr = mk(11, 0, 0, 0, 0, 0, 0, 0);
        wake(1);
        br_res = '{valid: 1'b1, hit: 1'b0};
        rst_ni = 1'b0;
        cycle();
        idle();
        xchk("reset_override", 1'b0, 0);
        xfull("reset_override_full", 1'b0);
        cycle();

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            idle();
            if ($urandom_range(199) == 0) rst_ni = 1'b0;
            if (m_pend ? ($urandom_range(9) == 0) : ($urandom_range(49) == 0)) begin
                br_res.valid = 1'b1;
                br_res.hit   = 1'($urandom_range(1));
            end
            if ($urandom_range(99) < 60) begin
                rinstr = mk(int'($urandom_range(63)),
                            1'($urandom_range(1)), int'($urandom_range(7)), ($urandom_range(9) < 3),
                            1'($urandom_range(1)), int'($urandom_range(7)), ($urandom_range(9) < 3),
                            !m_pend && !br_res.valid && ($urandom_range(7) == 0));
            end
            if ($urandom_range(9) < 4) wake(int'($urandom_range(7)));
            issue_ready = 1'($urandom_range(1));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
# issue_queue

In-order-allocated, out-of-order-issue queue directly downstream of `rename_2`. Accepts renamed instructions (`rinstr_t`), tracks source readiness via physical-register wakeup broadcasts, and issues the oldest instruction whose sources are all ready to execute. Squashes speculative entries on a branch mispredict and back-pressures rename through `iq_full_o`.

## Interface
- `DEPTH`, default 8: number of entries; must be ≥2.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_ni` input 1: synchronous, active-low reset.
- `rinstr_i` input `rinstr_t`: renamed instruction from `rename_2`. Fields: `valid`, `rd{valid,idx[5:0]}`, `rs1/rs2{valid,idx[5:0],ready}`, `is_branch`.
- `wakeup_i` input `p_reg_t`: result broadcast `{valid, idx[5:0], ready}`. Only `valid` and `idx` are used.
- `br_result_i` input `br_result_t`: `{valid, hit}`. `valid & !hit` is a mispredict.
- `iq_full_o` output 1: queue holds `DEPTH` entries; rename must stall.
- `issue_o` output `rinstr_t`: instruction offered to execute. Both `rs*.ready` are driven 1 when `valid`.
- `issue_ready_i` input 1: execute accepts `issue_o` this cycle.

## Operation
- Storage: compacting array `entry[0..DEPTH-1]`. Index 0 is oldest. Valid entries are contiguous from 0. `count` width is `$clog2(DEPTH+1)`.
- Per entry: the `rinstr_t` fields, plus a `spec` bit. `spec` means the entry was allocated while a branch was unresolved.
- `br_pending` flag:
  - Set when an accepted `rinstr_i` has `is_branch=1`.
  - Cleared by any `br_result_i.valid`.
  - At most one unresolved branch exists; rename guarantees this and the queue does not check it.
- Accept: `acc = rinstr_i.valid & !iq_full_o & !mispredict`.
  - The new entry's `spec` is `br_pending` as of that cycle. The branch entry itself is not spec.
  - `rinstr_i.valid` while full is dropped with no error.
- Source ready on allocation:
  - Invalid source: ready=1.
  - Otherwise ready = `rs.ready | (wakeup_i.valid & wakeup_i.idx == rs.idx)`.
- Wakeup: every valid entry with a valid, not-ready source whose `idx` matches `wakeup_i.idx` gets ready=1 at the edge.
- Select: lowest index with `valid & rs1.ready & rs2.ready` drives `issue_o` combinationally from registered state.
  - `issue_o.valid=0` if no such entry, or if a mispredict is present this cycle.
- Fire: `issue_o.valid & issue_ready_i`. The selected entry is removed; entries above it shift down by one. A new entry is written at `count-1` after the shift (at `count` if nothing fires).
- Mispredict (`br_result_i.valid & !br_result_i.hit`):
  - All `spec` entries are invalidated; survivors are compacted, preserving order.
  - No issue and no accept that cycle.
  - `br_pending` cleared.
- Hit (`valid & hit`): all `spec` bits cleared; `br_pending` cleared. Normal accept and issue proceed.
- `iq_full_o = (count == DEPTH)`, from registered count. A same-cycle fire does not free space for accept.

## Timing
- Reset (`rst_ni=0` at edge): all entries invalid, `count=0`, `br_pending=0`. Consequently `iq_full_o=0` and `issue_o='0` the following cycle.
- Reset overrides every other input the same edge, including mid-flush and mid-issue.
- Allocate-to-issue: an entry with both sources ready is offered on `issue_o` at earliest 1 cycle after acceptance. There is no bypass from `rinstr_i` to `issue_o`.
- Wakeup-to-issue: 1 cycle. A wakeup at edge N makes the entry selectable in cycle N+1.
- `issue_o` is held stable while `issue_ready_i=0`, unless an older entry becomes ready (re-select) or a mispredict occurs.
- Simultaneous accept + fire when `count=DEPTH`: fire only; the accept is blocked by `iq_full_o`.
- Simultaneous wakeup matching both an incoming source and a queued source: both are marked ready.
- `wakeup_i.valid` with no matching entry: no effect.

## Structure
- Shared package `ooo_pkg` holds:
  - `dinstr_t`, `rinstr_t`, `p_reg_t`, `br_result_t`
  - `P_REG_W=6`, `A_REG_W=5`
  - new `iq_entry_t` (`rinstr_t` + `spec`)
- Sub-module `iq_select`: parameterised find-first over a DEPTH-bit ready vector. Outputs `found` and `idx`.
- Compaction and shift logic stays in `issue_queue`.

## Test plan
- Reset then idle: `issue_o.valid=0`, `iq_full_o=0`. Accept `rs1={1,5,1}`, `rs2` invalid, `rd=40` → issued next cycle with `rd.idx=40`.
- Accept an entry with `rs1={1,33,0}`, hold `issue_ready_i=1`, drive `wakeup_i={1,33}` at cycle 4 → `issue_o.valid` rises at cycle 5, not earlier.
- Fill 8 not-ready entries → `iq_full_o=1`. A 9th valid `rinstr_i` is dropped. Wake entry 3's source → entry 3 issues, remaining order is preserved, and `iq_full_o` drops the cycle after the fire.
- Accept a branch, then 3 instructions (spec), then drive `br_result_i={1,0}` → only non-spec entries remain in order. No issue that cycle; `count` is reduced by 3.
- Same as above but `br_result_i={1,1}` → all 4 retained. A following mispredict without a new branch squashes nothing.
- Two ready entries at indices 0 and 2 with `issue_ready_i=0` for 3 cycles → `issue_o` holds entry 0 stable, then fires on ready, and entry 2 follows the next cycle.
